// File: rtl/csr_pkg.sv
// Shared definitions for the CSR/trap sequencer: CSR addresses, op and cause
// encodings, mstatus field positions, FSM states and mstatus update helpers.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    OP_CSRRW = 2'b00,
    OP_CSRRS = 2'b01,
    OP_ECALL = 2'b10,
    OP_MRET  = 2'b11
  } op_e;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSR,
    S_T_EPC,
    S_T_CAUSE,
    S_T_STAT,
    S_M_STAT,
    S_VEC
  } state_e;

  // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MPIE_BIT] = s[MIE_BIT];
    r[MIE_BIT] = 1'b0;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and leave MPIE set.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MIE_BIT] = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_seq_if.sv
// Bundle of the core request/response, redirect and CSR file port signals.
// The sequencer uses the slave view; the core/CSR-file side uses master.
interface csr_trap_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        irq;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        mstatus_mie;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, irq, csr_rdata, mstatus_mie,
    output req_ready, rsp_valid, rsp_rdata, redir_valid, redir_pc, csr_addr, csr_we, csr_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, irq, csr_rdata, mstatus_mie,
    input  req_ready, rsp_valid, rsp_rdata, redir_valid, redir_pc, csr_addr, csr_we, csr_wdata
  );
endinterface

// File: rtl/csr_trap_seq.sv
// Serialises CSR instructions, ECALL, MRET and timer-interrupt entry through the
// single read/write port of the machine-mode CSR file.
module csr_trap_seq
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  csr_trap_seq_if.slave bus
);

  state_e      state_reg, state_next;
  op_e         op_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] pc_reg;
  logic [31:0] cause_reg;
  logic        vec_mtvec_reg;
  logic        rsp_valid_reg, redir_valid_reg;
  logic [31:0] rsp_rdata_reg, redir_pc_reg;

  logic        accept;
  logic        take_irq;
  logic [31:0] tvec_masked;
  logic [31:0] vec_target;
  logic [11:0] csr_addr_c;
  logic        csr_we_c;
  logic [31:0] csr_wdata_c;

  assign bus.req_ready = rst_n && (state_reg == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign take_irq      = bus.irq && bus.mstatus_mie;

  // An all-zero (masked) mtvec means the vector was never programmed.
  assign tvec_masked = bus.csr_rdata & ~32'h3;
  assign vec_target  = !vec_mtvec_reg       ? bus.csr_rdata :
                       (tvec_masked == '0)  ? RESET_VEC     : tvec_masked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (take_irq) begin
            state_next = S_T_EPC;
          end else begin
            case (op_e'(bus.req_op))
              OP_CSRRW, OP_CSRRS: state_next = S_CSR;
              OP_ECALL:           state_next = S_T_EPC;
              default:            state_next = S_M_STAT;
            endcase
          end
        end
      end
      S_CSR:     state_next = S_IDLE;
      S_T_EPC:   state_next = S_T_CAUSE;
      S_T_CAUSE: state_next = S_T_STAT;
      S_T_STAT:  state_next = S_VEC;
      S_M_STAT:  state_next = S_VEC;
      S_VEC:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    csr_addr_c  = '0;
    csr_we_c    = 1'b0;
    csr_wdata_c = '0;
    case (state_reg)
      S_CSR: begin
        csr_addr_c  = addr_reg;
        csr_wdata_c = (op_reg == OP_CSRRW) ? wdata_reg : (bus.csr_rdata | wdata_reg);
        csr_we_c    = (op_reg == OP_CSRRW) || (wdata_reg != '0);
      end
      S_T_EPC: begin
        csr_addr_c  = CSR_MEPC;
        csr_we_c    = 1'b1;
        csr_wdata_c = pc_reg;
      end
      S_T_CAUSE: begin
        csr_addr_c  = CSR_MCAUSE;
        csr_we_c    = 1'b1;
        csr_wdata_c = cause_reg;
      end
      S_T_STAT: begin
        csr_addr_c  = CSR_MSTATUS;
        csr_we_c    = 1'b1;
        csr_wdata_c = trap_mstatus(bus.csr_rdata);
      end
      S_M_STAT: begin
        csr_addr_c  = CSR_MSTATUS;
        csr_we_c    = 1'b1;
        csr_wdata_c = mret_mstatus(bus.csr_rdata);
      end
      S_VEC: begin
        csr_addr_c = vec_mtvec_reg ? CSR_MTVEC : CSR_MEPC;
      end
      default: begin
        csr_addr_c = '0;
      end
    endcase
  end

  assign bus.csr_addr  = csr_addr_c;
  assign bus.csr_we    = csr_we_c;
  assign bus.csr_wdata = csr_wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg          <= OP_CSRRW;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      pc_reg          <= '0;
      cause_reg       <= '0;
      vec_mtvec_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      redir_valid_reg <= 1'b0;
      redir_pc_reg    <= '0;
    end else begin
      rsp_valid_reg   <= (state_reg == S_CSR);
      redir_valid_reg <= (state_reg == S_VEC);
      if (state_reg == S_CSR) begin
        rsp_rdata_reg <= bus.csr_rdata;
      end
      if (state_reg == S_VEC) begin
        redir_pc_reg <= vec_target;
      end
      if (accept) begin
        op_reg        <= op_e'(bus.req_op);
        addr_reg      <= bus.req_addr;
        wdata_reg     <= bus.req_wdata;
        pc_reg        <= bus.req_pc;
        cause_reg     <= take_irq ? CAUSE_M_TIMER : CAUSE_ECALL_M;
        // Only a genuine MRET vectors through mepc; every trap uses mtvec.
        vec_mtvec_reg <= take_irq || (op_e'(bus.req_op) != OP_MRET);
      end
    end
  end

  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.redir_valid = redir_valid_reg;
  assign bus.redir_pc    = redir_pc_reg;

endmodule

// File: doc/csr_trap_seq.md
# csr_trap_seq

Multi-cycle sequencer sitting between the core's execute stage and the machine-mode CSR register file. It accepts CSR instructions (CSRRW/CSRRS), ECALL and MRET, and samples a level-sensitive machine timer interrupt. It serialises every CSR update through the file's single read/write port and returns either read data or a PC redirect. The CSR file itself stays a plain storage array with one combinational read port and one synchronous write port.

## Interface
Parameters:
- `RESET_VEC`, 32'h8000_0000: redirect PC emitted if mtvec reads as 0

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  core presents an instruction at commit
- `req_ready`  out  1  sequencer accepts; transfer when both high
- `req_op`  in  2  00 CSRRW, 01 CSRRS, 10 ECALL, 11 MRET
- `req_addr`  in  12  CSR address (CSR ops only)
- `req_wdata`  in  32  rs1 value (CSR ops only)
- `req_pc`  in  32  PC of the presented instruction
- `irq`  in  1  machine timer interrupt, level
- `rsp_valid`  out  1  one-cycle pulse; `rsp_rdata` is valid
- `rsp_rdata`  out  32  old CSR value for rd
- `redir_valid`  out  1  one-cycle pulse; core loads `redir_pc`
- `redir_pc`  out  32  trap vector or return address
- `csr_addr`  out  12  CSR file address
- `csr_we`  out  1  CSR file write enable
- `csr_wdata`  out  32  CSR file write data
- `csr_rdata`  in  32  CSR file combinational read of `csr_addr`
- `mstatus_mie`  in  1  live mstatus.MIE (bit 3) from CSR file

## Operation
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- States: IDLE, CSR, T_EPC, T_CAUSE, T_STAT, M_STAT, VEC.
- IDLE: `req_ready`=1. On handshake, latch op/addr/wdata/pc.
- Interrupt check takes priority. If `irq & mstatus_mie` in the handshake cycle, the request is consumed but not executed. Latch cause 32'h8000_0007 and go to T_EPC.
- Otherwise, the next state depends on `req_op`:
  - CSRRW/CSRRS go to CSR.
  - ECALL latches cause 32'd11 and goes to T_EPC.
  - MRET goes to M_STAT.
- CSR: drive `csr_addr`=addr and capture `csr_rdata` into `rsp_rdata`.
  - CSRRW writes wdata.
  - CSRRS writes rdata|wdata, and performs no write when wdata==0.
  - Then go to IDLE with `rsp_valid` set.
- T_EPC: write mepc=pc, then T_CAUSE.
- T_CAUSE: write mcause=latched cause, then T_STAT.
- T_STAT: read mstatus and write it with MPIE(bit 7)=MIE(bit 3), MIE=0, MPP(bits 12:11)=2'b11. Then VEC, selecting mtvec.
- M_STAT: read mstatus and write it with MIE=MPIE, MPIE=1. Then VEC, selecting mepc.
- VEC: read the selected CSR and register `redir_pc`.
  - mtvec is masked with bits [1:0] cleared; direct mode only.
  - If the mtvec result is 0, use `RESET_VEC`.
  - Pulse `redir_valid` and go to IDLE.
- In all non-write states `csr_we`=0. `csr_addr`/`csr_wdata` are combinational from state and latched fields.

## Timing
- Reset values: state IDLE; `rsp_valid`, `redir_valid` = 0; `rsp_rdata`, `redir_pc` = 0; latched fields 0. `req_ready`=0 while `rst_n` low.
- `req_ready` = (state==IDLE) and is never high in other states. The core must hold `req_*` stable until the handshake.
- Latency from the handshake edge:
  - CSR op: `rsp_valid` 2 edges later.
  - ECALL or interrupt: `redir_valid` 5 edges later.
  - MRET: `redir_valid` 3 edges later.
- `rsp_valid`/`redir_valid` are high exactly one cycle, coinciding with `req_ready`=1. Back-to-back requests are allowed in that cycle.
- `irq` is sampled only in the handshake cycle. `irq` rising mid-sequence is ignored until the next handshake. `irq` with MIE=0 is ignored.
- Reset asserted mid-sequence aborts immediately with no further `csr_we`. A partially written trap, e.g. mepc written but mstatus not, is accepted.
- Arithmetic: all 32-bit bitwise ops, no carries.

## Structure
- Shared package `csr_pkg`:
  - CSR address constants.
  - op encoding.
  - cause constants (11, 0x8000_0007).
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - state enum.
- Single module with no sub-module. The mstatus next-value logic may be a function in `csr_pkg`.

## Test plan
- CSRRW 0x305 wdata 0x8000_0100, file holds 0 -> one write of 0x8000_0100 to 0x305; `rsp_valid` with rdata 0 two edges after handshake.
- CSRRS 0x300 wdata 0 with mstatus 0x88 -> `csr_we` never high; rdata 0x88.
- ECALL pc 0x8000_0040, mtvec 0x8000_0103, mstatus 0x8 -> writes in order: mepc 0x8000_0040, mcause 11, mstatus 0x1880; `redir_pc` 0x8000_0100 five edges after handshake.
- MRET with mepc 0x8000_0044, mstatus 0x1880 -> mstatus written 0x1888; `redir_pc` 0x8000_0044 three edges after handshake.
- `irq`=1, MIE=1 at handshake of a CSRRW, pc 0x8000_0010 -> no CSRRW write and no `rsp_valid`; mcause 0x8000_0007, mepc 0x8000_0010, redirect to mtvec. Repeat with MIE=0 -> CSRRW executes normally.
- `rst_n` low during T_CAUSE -> all outputs 0 and `csr_we` low at once; after release `req_ready`=1 and a new CSRRW completes normally.
